// File: rtl/pe_sched_pkg.sv
// Shared types and constants for the 3-way alignment PE scheduler.
// Optional feature macro used by the design: BEST_LOC_EN.
package pe_sched_pkg;

    localparam int SCORE_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic signed [1:0] pair_score_t;
    typedef logic signed [2:0] triple_score_t;

    localparam logic signed [SCORE_W-1:0] MIN_SCORE = {1'b1, {(SCORE_W-1){1'b0}}};

    function automatic pair_score_t pair_score(input logic [1:0] x, input logic [1:0] y);
        pair_score_t s;
        if (x == y) begin
            s = 2'sb01;
        end else begin
            s = 2'sb11;
        end
        return s;
    endfunction

endpackage

// File: rtl/pe_sched_if.sv
// Scheduler <-> PE bus: cell coordinates out, bases back, scores out, final result back.
interface pe_sched_if #(
    parameter int LEN_W   = 6,
    parameter int SCORE_W = pe_sched_pkg::SCORE_W
);
    import pe_sched_pkg::*;

    logic                      pe_ready;
    logic                      cell_valid;
    logic [LEN_W-1:0]          cell_i;
    logic [LEN_W-1:0]          cell_j;
    logic [LEN_W-1:0]          cell_k;
    logic [1:0]                a_base;
    logic [1:0]                b_base;
    logic [1:0]                c_base;
    logic                      score_valid;
    pair_score_t               Score2AB;
    pair_score_t               Score2AC;
    pair_score_t               Score2BC;
    triple_score_t             Score3ABC;
    logic signed [SCORE_W-1:0] Final_score;

    modport master (
        input  pe_ready, a_base, b_base, c_base, Final_score,
        output cell_valid, cell_i, cell_j, cell_k,
               score_valid, Score2AB, Score2AC, Score2BC, Score3ABC
    );

    modport slave (
        output pe_ready, a_base, b_base, c_base, Final_score,
        input  cell_valid, cell_i, cell_j, cell_k,
               score_valid, Score2AB, Score2AC, Score2BC, Score3ABC
    );

endinterface

// File: rtl/pe_sched_score_gen.sv
// Combinational match scoring of three bases: pairwise +1/-1 and their sum.
module score_gen
    import pe_sched_pkg::*;
(
    input  logic [1:0]    i_a_base,
    input  logic [1:0]    i_b_base,
    input  logic [1:0]    i_c_base,
    output pair_score_t   o_ab,
    output pair_score_t   o_ac,
    output pair_score_t   o_bc,
    output triple_score_t o_abc
);

    assign o_ab  = pair_score(i_a_base, i_b_base);
    assign o_ac  = pair_score(i_a_base, i_c_base);
    assign o_bc  = pair_score(i_b_base, i_c_base);
    // sign-extend each pair score before summing so -3 wraps correctly in 3 bits
    assign o_abc = {o_ab[1], o_ab} + {o_ac[1], o_ac} + {o_bc[1], o_bc};

endmodule

// File: rtl/pe_sched.sv
// Wavefront scheduler for a 3-D alignment PE: sweeps planes d=i+j+k, scores cells, tracks the best result.
// Define BEST_LOC_EN to also report the coordinates of the best cell (best_i/best_j/best_k).
module pe_sched #(
    parameter int LEN_W    = 6,
    parameter int SCORE_W  = pe_sched_pkg::SCORE_W,
    parameter int PIPE_LAT = 3
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      start,
    input  logic [LEN_W-1:0]          len_a,
    input  logic [LEN_W-1:0]          len_b,
    input  logic [LEN_W-1:0]          len_c,
    output logic                      busy,
    output logic                      done,
    output logic signed [SCORE_W-1:0] best_score,
`ifdef BEST_LOC_EN
    output logic [LEN_W-1:0]          best_i,
    output logic [LEN_W-1:0]          best_j,
    output logic [LEN_W-1:0]          best_k,
`endif
    pe_sched_if.master                pe
);
    import pe_sched_pkg::*;

    localparam int DW  = LEN_W + 2;
    localparam int DCW = $clog2(PIPE_LAT + 3);
    localparam logic signed [SCORE_W-1:0] BEST_INIT = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [LEN_W-1:0] L_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] L_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    D_ZERO  = {DW{1'b0}};
    localparam logic [DW-1:0]    D_ONE   = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    D_FIRST = {{(DW-2){1'b0}}, 2'b11};
    localparam logic [DCW-1:0]   DR_ZERO = {DCW{1'b0}};
    localparam logic [DCW-1:0]   DR_ONE  = {{(DCW-1){1'b0}}, 1'b1};
    localparam logic [DCW-1:0]   DR_LAST = DCW'(PIPE_LAT + 1);

    state_t                    r_state, w_state_nxt;
    logic [LEN_W-1:0]          r_la, r_lb, r_lc;
    logic [LEN_W-1:0]          r_i, r_j, w_i_nxt, w_j_nxt;
    logic [DW-1:0]             r_d, w_d_nxt, r_d_last;
    logic [DW-1:0]             w_ij, w_k_full;
    logic [DCW-1:0]            r_drain, w_drain_nxt;
    logic                      w_accept, w_len_zero, w_slot_ok, w_last_slot, w_cell_valid;
    logic                      r_v1, r_score_valid;
    logic [PIPE_LAT-1:0]       r_res_v;
    logic [PIPE_LAT:0]         w_res_shift;
    logic                      w_best_upd;
    pair_score_t               w_ab, w_ac, w_bc, r_ab, r_ac, r_bc;
    triple_score_t             w_abc, r_abc;
    logic signed [SCORE_W-1:0] r_best;

    assign w_len_zero   = (len_a == L_ZERO) || (len_b == L_ZERO) || (len_c == L_ZERO);
    assign w_ij         = {2'b00, r_i} + {2'b00, r_j};
    assign w_k_full     = r_d - w_ij;
    assign w_slot_ok    = (r_d > w_ij) && (w_k_full <= {2'b00, r_lc});
    assign w_last_slot  = (r_i == r_la) && (r_j == r_lb) && (r_d == r_d_last);
    assign w_cell_valid = (r_state == SWEEP) && pe.pe_ready && w_slot_ok;
    assign w_res_shift  = {r_res_v, r_score_valid};
    assign w_best_upd   = r_res_v[PIPE_LAT-1] && (pe.Final_score > r_best);

    score_gen u_score_gen (
        .i_a_base (pe.a_base),
        .i_b_base (pe.b_base),
        .i_c_base (pe.c_base),
        .o_ab     (w_ab),
        .o_ac     (w_ac),
        .o_bc     (w_bc),
        .o_abc    (w_abc)
    );

    // next-state and sweep-counter logic; j is innermost, then i, then plane d
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_d_nxt     = r_d;
        w_drain_nxt = r_drain;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_i_nxt     = L_ONE;
                    w_j_nxt     = L_ONE;
                    w_d_nxt     = D_FIRST;
                    w_drain_nxt = DR_ZERO;
                    if (w_len_zero) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SWEEP;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SWEEP: begin
                if (!pe.pe_ready) begin
                    w_state_nxt = SWEEP;
                end else if (w_last_slot) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = DR_ZERO;
                end else if (r_j != r_lb) begin
                    w_j_nxt = r_j + L_ONE;
                end else if (r_i != r_la) begin
                    w_j_nxt = L_ONE;
                    w_i_nxt = r_i + L_ONE;
                end else begin
                    w_j_nxt = L_ONE;
                    w_i_nxt = L_ONE;
                    w_d_nxt = r_d + D_ONE;
                end
            end
            DRAIN: begin
                if (r_drain == DR_LAST) begin
                    w_state_nxt = DONE;
                end else begin
                    w_drain_nxt = r_drain + DR_ONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // state, sweep counters and job lengths latched on the accepted start
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_i      <= L_ZERO;
            r_j      <= L_ZERO;
            r_d      <= D_ZERO;
            r_drain  <= DR_ZERO;
            r_la     <= L_ZERO;
            r_lb     <= L_ZERO;
            r_lc     <= L_ZERO;
            r_d_last <= D_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_d     <= w_d_nxt;
            r_drain <= w_drain_nxt;
            if (w_accept) begin
                r_la     <= len_a;
                r_lb     <= len_b;
                r_lc     <= len_c;
                r_d_last <= {2'b00, len_a} + {2'b00, len_b} + {2'b00, len_c};
            end
        end
    end

    // base capture, score register, result-valid shift chain and best tracking
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_v1          <= 1'b0;
            r_score_valid <= 1'b0;
            r_res_v       <= {PIPE_LAT{1'b0}};
            r_ab          <= 2'sb00;
            r_ac          <= 2'sb00;
            r_bc          <= 2'sb00;
            r_abc         <= 3'sb000;
            r_best        <= BEST_INIT;
        end else begin
            r_v1          <= w_cell_valid;
            r_score_valid <= r_v1;
            r_res_v       <= w_res_shift[PIPE_LAT-1:0];
            if (r_v1) begin
                r_ab  <= w_ab;
                r_ac  <= w_ac;
                r_bc  <= w_bc;
                r_abc <= w_abc;
            end
            if (w_accept) begin
                r_best <= BEST_INIT;
            end else if (w_best_upd) begin
                r_best <= pe.Final_score;
            end
        end
    end

`ifdef BEST_LOC_EN
    localparam int CW = 3 * LEN_W;

    logic [CW-1:0] r_loc1, r_loc2, r_best_loc;
    logic [CW-1:0] r_loc_pipe [PIPE_LAT];

    // coordinates ride alongside the valid pipeline so they line up with Final_score
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_loc1     <= {CW{1'b0}};
            r_loc2     <= {CW{1'b0}};
            r_best_loc <= {CW{1'b0}};
            for (int n = 0; n < PIPE_LAT; n++) begin
                r_loc_pipe[n] <= {CW{1'b0}};
            end
        end else begin
            if (w_cell_valid) begin
                r_loc1 <= {r_i, r_j, w_k_full[LEN_W-1:0]};
            end
            if (r_v1) begin
                r_loc2 <= r_loc1;
            end
            r_loc_pipe[0] <= r_loc2;
            for (int n = 1; n < PIPE_LAT; n++) begin
                r_loc_pipe[n] <= r_loc_pipe[n-1];
            end
            if (w_accept) begin
                r_best_loc <= {CW{1'b0}};
            end else if (w_best_upd) begin
                r_best_loc <= r_loc_pipe[PIPE_LAT-1];
            end
        end
    end

    assign best_i = r_best_loc[CW-1 -: LEN_W];
    assign best_j = r_best_loc[2*LEN_W-1 -: LEN_W];
    assign best_k = r_best_loc[LEN_W-1:0];
`endif

    assign pe.cell_valid  = w_cell_valid;
    assign pe.cell_i      = w_cell_valid ? r_i : L_ZERO;
    assign pe.cell_j      = w_cell_valid ? r_j : L_ZERO;
    assign pe.cell_k      = w_cell_valid ? w_k_full[LEN_W-1:0] : L_ZERO;
    assign pe.score_valid = r_score_valid;
    assign pe.Score2AB    = r_ab;
    assign pe.Score2AC    = r_ac;
    assign pe.Score2BC    = r_bc;
    assign pe.Score3ABC   = r_abc;
    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign best_score     = r_best;

endmodule
